cache_control: RTL and testbench
================================

# cache_control

Sequencing FSM for the 2-way set-associative L1 cache datapath. Decodes CPU requests against the datapath's hit/dirty/LRU status, drives every datapath load/mux select, and runs write-back and line-fill transactions on the cacheline adapter. One instance sits beside each cache datapath (I-cache and D-cache) between the pipeline memory stage and the arbiter.

## Interface
- No parameters. Select encodings come from the `cache_types` package: `write_en_mux`, `data_in_mux`, `data_out_mux`, `address_mux`.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_read, mem_write  in  1 each  CPU request, held until mem_resp
- mem_resp  out  1  one-cycle request-complete pulse
- hit, hit_0, hit_1  in  1 each  datapath tag-compare results
- dirty  in  1  dirty bit of the LRU (victim) way
- lru_out  in  1  victim way: 0 = way 0, 1 = way 1
- pmem_resp  in  1  cacheline adapter done
- pmem_read, pmem_write  out  1 each  adapter requests, held until pmem_resp
- load_dirty_0/1, load_tag_0/1, load_valid_0/1, load_lru  out  1 each  array load strobes
- write_en_mux_sel_0/1  out  enum  per-way data write enable: write_none, byte_en or write_all
- data_in_mux_sel  out  enum  wdata or rdata
- data_out_mux_sel  out  enum  data_out_0 or data_out_1
- addr_mux_sel  out  enum  cache (victim write-back address) or memory (CPU address)

## Operation
- States: CHECK, WRITEBACK, FILL. Reset state is CHECK.
- Output defaults, also the reset values:
  - all strobes and handshakes 0
  - write_en sels write_none; data_in wdata; data_out data_out_0; addr memory
- CHECK with no request: hold all defaults.
- CHECK, request, hit:
  - mem_resp=1; load_lru=1 (LRU datapath input is hit_0); data_out_mux_sel = hit way.
  - Write hit also sets: data_in wdata; hit way's write_en byte_en; hit way's load_dirty=1.
  - Stay in CHECK.
- CHECK, request, miss: go to WRITEBACK if dirty=1, otherwise to FILL. No mem_resp.
- WRITEBACK:
  - pmem_write=1; addr cache; data_out_mux_sel = lru_out way.
  - On pmem_resp go to FILL.
- FILL:
  - pmem_read=1; addr memory; data_in rdata.
  - On pmem_resp, for the lru_out way: write_en write_all, plus load_tag, load_valid and load_dirty all 1. Dirty loads mem_write. Then go to CHECK.
  - The re-check hits, and completes the request.
- mem_read and mem_write both high: treated as a write.
- A request dropped mid-miss does not abort. The FSM finishes the fill and returns to CHECK.
- lru_out and dirty are sampled combinationally. The victim way cannot change during a miss, because no LRU load occurs outside a hit.

## Timing
- Hit: mem_resp in the same cycle the request is first seen in CHECK (0-cycle added latency).
- Clean miss: 1 (CHECK) + fill cycles up to and including pmem_resp + 1 (CHECK hit) cycles.
- Dirty miss: clean-miss latency plus the write-back cycles up to and including pmem_resp.
- pmem_read and pmem_write are never both high. Each deasserts the cycle after pmem_resp.
- Reset mid-miss: immediate return to CHECK with default outputs. The adapter is reset by the same rst.

## Configuration
- CACHE_PERF_CTR_EN defined:
  - Adds outputs hit_count and miss_count, 32 bits each.
  - A counter increments once per CHECK-state hit (request completion) or per CHECK-state miss decision respectively.
  - Both counters wrap at 2^32 and clear on rst.
- CACHE_PERF_CTR_EN undefined: no ports or counter logic are present; FSM behaviour is identical.

## Test plan
- Read hit: hit=1, hit_1=1, mem_read=1 -> in the same cycle mem_resp=1, load_lru=1, data_out_mux_sel=data_out_1; no pmem activity.
- Write hit: mem_write=1, hit_0=1 -> write_en_mux_sel_0=byte_en, load_dirty_0=1, mem_resp=1; way 1 write_en stays write_none.
- Clean read miss: hit=0, dirty=0, lru_out=0, pmem_resp after 4 cycles:
  - pmem_read high 4 cycles with addr memory;
  - on pmem_resp: write_all, load_tag_0, load_valid_0 and load_dirty_0;
  - next cycle hit -> mem_resp.
- Dirty write miss: lru_out=1, dirty=1:
  - pmem_write with addr cache and data_out_1 until pmem_resp;
  - then FILL into way 1 with load_dirty_1=1 (mem_write);
  - then the CHECK write hit.
- Reset asserted (rst=0) during WRITEBACK -> all outputs take their reset values immediately; after release, state is CHECK.
- With CACHE_PERF_CTR_EN, 3 hits + 1 miss -> hit_count=4 (the miss resolves as a hit), miss_count=1.

Source files
------------

// File: rtl/cache_types.sv
// rtl/cache_types.sv - select encodings shared by the cache controller and datapath
package cache_types;

    typedef enum logic [1:0] {
        write_none = 2'd0,
        byte_en    = 2'd1,
        write_all  = 2'd2
    } write_en_mux;

    typedef enum logic {
        wdata = 1'b0,
        rdata = 1'b1
    } data_in_mux;

    typedef enum logic {
        data_out_0 = 1'b0,
        data_out_1 = 1'b1
    } data_out_mux;

    typedef enum logic {
        memory = 1'b0,
        cache  = 1'b1
    } address_mux;

endpackage

// File: rtl/cache_control_if.sv
// rtl/cache_control_if.sv - CPU, datapath and adapter signals of cache_control; CACHE_PERF_CTR_EN adds counters
interface cache_control_if;
    import cache_types::*;

    logic        mem_read;
    logic        mem_write;
    logic        mem_resp;
    logic        hit;
    logic        hit_0;
    logic        hit_1;
    logic        dirty;
    logic        lru_out;
    logic        pmem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic        load_dirty_0;
    logic        load_dirty_1;
    logic        load_tag_0;
    logic        load_tag_1;
    logic        load_valid_0;
    logic        load_valid_1;
    logic        load_lru;
    write_en_mux write_en_mux_sel_0;
    write_en_mux write_en_mux_sel_1;
    data_in_mux  data_in_mux_sel;
    data_out_mux data_out_mux_sel;
    address_mux  addr_mux_sel;
`ifdef CACHE_PERF_CTR_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    modport master (
`ifdef CACHE_PERF_CTR_EN
        output hit_count, miss_count,
`endif
        input  mem_read, mem_write, hit, hit_0, hit_1, dirty, lru_out, pmem_resp,
        output mem_resp, pmem_read, pmem_write,
        output load_dirty_0, load_dirty_1, load_tag_0, load_tag_1,
        output load_valid_0, load_valid_1, load_lru,
        output write_en_mux_sel_0, write_en_mux_sel_1,
        output data_in_mux_sel, data_out_mux_sel, addr_mux_sel
    );

    modport slave (
`ifdef CACHE_PERF_CTR_EN
        input  hit_count, miss_count,
`endif
        output mem_read, mem_write, hit, hit_0, hit_1, dirty, lru_out, pmem_resp,
        input  mem_resp, pmem_read, pmem_write,
        input  load_dirty_0, load_dirty_1, load_tag_0, load_tag_1,
        input  load_valid_0, load_valid_1, load_lru,
        input  write_en_mux_sel_0, write_en_mux_sel_1,
        input  data_in_mux_sel, data_out_mux_sel, addr_mux_sel
    );
endinterface

// File: rtl/cache_control.sv
// rtl/cache_control.sv - 2-way L1 cache sequencing FSM (CHECK/WRITEBACK/FILL); CACHE_PERF_CTR_EN adds hit/miss counters
module cache_control
    import cache_types::*;
(
    input  logic            clk,
    input  logic            rst,
    cache_control_if.master bus
);

    localparam logic [1:0] CHECK     = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FILL      = 2'd2;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       req;

    assign req = bus.mem_read | bus.mem_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CHECK;
        else      state <= next_state;
    end

    // Outputs are forced to defaults while reset is held so they change immediately.
    always_comb begin
        next_state             = state;
        bus.mem_resp           = 1'b0;
        bus.pmem_read          = 1'b0;
        bus.pmem_write         = 1'b0;
        bus.load_dirty_0       = 1'b0;
        bus.load_dirty_1       = 1'b0;
        bus.load_tag_0         = 1'b0;
        bus.load_tag_1         = 1'b0;
        bus.load_valid_0       = 1'b0;
        bus.load_valid_1       = 1'b0;
        bus.load_lru           = 1'b0;
        bus.write_en_mux_sel_0 = write_none;
        bus.write_en_mux_sel_1 = write_none;
        bus.data_in_mux_sel    = wdata;
        bus.data_out_mux_sel   = data_out_0;
        bus.addr_mux_sel       = memory;
        if (rst) begin
            case (state)
                CHECK: begin
                    if (req && bus.hit) begin
                        bus.mem_resp         = 1'b1;
                        bus.load_lru         = 1'b1;
                        bus.data_out_mux_sel = bus.hit_1 ? data_out_1 : data_out_0;
                        if (bus.mem_write) begin
                            if (bus.hit_1) begin
                                bus.write_en_mux_sel_1 = byte_en;
                                bus.load_dirty_1       = 1'b1;
                            end else begin
                                bus.write_en_mux_sel_0 = byte_en;
                                bus.load_dirty_0       = 1'b1;
                            end
                        end
                    end else if (req) begin
                        next_state = bus.dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write       = 1'b1;
                    bus.addr_mux_sel     = cache;
                    bus.data_out_mux_sel = bus.lru_out ? data_out_1 : data_out_0;
                    if (bus.pmem_resp) next_state = FILL;
                end
                FILL: begin
                    bus.pmem_read       = 1'b1;
                    bus.data_in_mux_sel = rdata;
                    if (bus.pmem_resp) begin
                        // Dirty strobe loads mem_write, so a write miss leaves the line dirty.
                        if (bus.lru_out) begin
                            bus.write_en_mux_sel_1 = write_all;
                            bus.load_tag_1         = 1'b1;
                            bus.load_valid_1       = 1'b1;
                            bus.load_dirty_1       = 1'b1;
                        end else begin
                            bus.write_en_mux_sel_0 = write_all;
                            bus.load_tag_0         = 1'b1;
                            bus.load_valid_0       = 1'b1;
                            bus.load_dirty_0       = 1'b1;
                        end
                        next_state = CHECK;
                    end
                end
                default: next_state = CHECK;
            endcase
        end
    end

`ifdef CACHE_PERF_CTR_EN
    logic [31:0] hit_ctr;
    logic [31:0] miss_ctr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_ctr  <= 32'd0;
            miss_ctr <= 32'd0;
        end else if (state == CHECK && req) begin
            if (bus.hit) hit_ctr  <= hit_ctr + 32'd1;
            else         miss_ctr <= miss_ctr + 32'd1;
        end
    end

    assign bus.hit_count  = hit_ctr;
    assign bus.miss_count = miss_ctr;
`endif

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - randomized transaction-level bench for cache_control
module tb_cache_control;
    import cache_types::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_control_if bus();
    cache_control dut (.clk(clk), .rst(rst), .bus(bus));

    int tests_run    = 0;
    int tests_failed = 0;
    int unsigned exp_hits   = 0;
    int unsigned exp_misses = 0;
    logic [16:0] default_outs;

    function automatic logic [16:0] outs();
        return {bus.mem_resp, bus.pmem_read, bus.pmem_write,
                bus.load_dirty_0, bus.load_dirty_1, bus.load_tag_0, bus.load_tag_1,
                bus.load_valid_0, bus.load_valid_1, bus.load_lru,
                bus.write_en_mux_sel_0, bus.write_en_mux_sel_1,
                bus.data_in_mux_sel, bus.data_out_mux_sel, bus.addr_mux_sel};
    endfunction

    task automatic idle_inputs();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.hit       = 1'b0;
        bus.hit_0     = 1'b0;
        bus.hit_1     = 1'b0;
        bus.dirty     = 1'b0;
        bus.lru_out   = 1'b0;
        bus.pmem_resp = 1'b0;
    endtask

    // One CPU request with the bench playing datapath and cacheline adapter.
    task automatic do_txn(input bit wr, input bit rd_too, input bit is_hit, input bit hway,
                          input bit dty, input bit lru, input int fill_lat, input int wb_lat);
        int cyc, rd_cyc, wr_cyc, exp_lat;
        bit cur_hit, cur_way, done;
        write_en_mux we_hit, we_oth;
        cur_hit = is_hit; cur_way = hway; done = 0;
        cyc = 0; rd_cyc = 0; wr_cyc = 0;
        exp_lat = is_hit ? 1 : 2 + fill_lat + (dty ? wb_lat : 0);
        bus.mem_write = wr;
        bus.mem_read  = !wr || rd_too;
        bus.dirty     = dty;
        bus.lru_out   = lru;
        while (!done && cyc < 200) begin
            bus.hit       = cur_hit;
            bus.hit_0     = cur_hit && !cur_way;
            bus.hit_1     = cur_hit && cur_way;
            bus.pmem_resp = 1'b0;
            #1;
            cyc++;
            tests_run++;
            if (bus.pmem_read && bus.pmem_write) begin
                tests_failed++;
                $display("FAIL pmem_exclusive: read=%0b write=%0b required not both", bus.pmem_read, bus.pmem_write);
            end
            if (bus.pmem_write) begin
                wr_cyc++;
                tests_run++;
                if (bus.addr_mux_sel !== cache || bus.data_out_mux_sel !== data_out_mux'(lru)) begin
                    tests_failed++;
                    $display("FAIL wb_selects: addr=%0d dout=%0d required addr=%0d dout=%0d",
                             bus.addr_mux_sel, bus.data_out_mux_sel, cache, lru);
                end
                if (wr_cyc == wb_lat) begin
                    bus.pmem_resp = 1'b1;
                    #1;
                end
            end else if (bus.pmem_read) begin
                rd_cyc++;
                tests_run++;
                if (bus.addr_mux_sel !== memory || bus.data_in_mux_sel !== rdata) begin
                    tests_failed++;
                    $display("FAIL fill_selects: addr=%0d din=%0d required addr=%0d din=%0d",
                             bus.addr_mux_sel, bus.data_in_mux_sel, memory, rdata);
                end
                if (rd_cyc == fill_lat) begin
                    bus.pmem_resp = 1'b1;
                    #1;
                    tests_run++;
                    if ((lru ? bus.write_en_mux_sel_1 : bus.write_en_mux_sel_0) !== write_all ||
                        (lru ? bus.write_en_mux_sel_0 : bus.write_en_mux_sel_1) !== write_none ||
                        {bus.load_tag_1, bus.load_valid_1, bus.load_dirty_1} !== {3{lru}} ||
                        {bus.load_tag_0, bus.load_valid_0, bus.load_dirty_0} !== {3{!lru}}) begin
                        tests_failed++;
                        $display("FAIL fill_strobes: we0=%0d we1=%0d tvd0=%b%b%b tvd1=%b%b%b required victim way %0d",
                                 bus.write_en_mux_sel_0, bus.write_en_mux_sel_1,
                                 bus.load_tag_0, bus.load_valid_0, bus.load_dirty_0,
                                 bus.load_tag_1, bus.load_valid_1, bus.load_dirty_1, lru);
                    end
                    cur_hit = 1'b1;
                    cur_way = lru;
                end
            end
            if (bus.mem_resp) begin
                done = 1;
                we_hit = wr ? byte_en : write_none;
                we_oth = write_none;
                tests_run++;
                if (cyc != exp_lat) begin
                    tests_failed++;
                    $display("FAIL latency: got %0d cycles required %0d", cyc, exp_lat);
                end
                tests_run++;
                if (bus.load_lru !== 1'b1 || bus.data_out_mux_sel !== data_out_mux'(cur_way) ||
                    bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 ||
                    (cur_way ? bus.write_en_mux_sel_1 : bus.write_en_mux_sel_0) !== we_hit ||
                    (cur_way ? bus.write_en_mux_sel_0 : bus.write_en_mux_sel_1) !== we_oth ||
                    bus.load_dirty_1 !== (wr && cur_way) || bus.load_dirty_0 !== (wr && !cur_way) ||
                    bus.data_in_mux_sel !== wdata) begin
                    tests_failed++;
                    $display("FAIL hit_outputs: lru=%0b dout=%0d we0=%0d we1=%0d ld=%b%b required way %0d write %0b",
                             bus.load_lru, bus.data_out_mux_sel, bus.write_en_mux_sel_0,
                             bus.write_en_mux_sel_1, bus.load_dirty_0, bus.load_dirty_1, cur_way, wr);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL timeout: no mem_resp after %0d cycles required %0d", cyc, exp_lat);
        end
        tests_run++;
        if (rd_cyc != (is_hit ? 0 : fill_lat) || wr_cyc != ((is_hit || !dty) ? 0 : wb_lat)) begin
            tests_failed++;
            $display("FAIL pmem_cycles: read=%0d write=%0d required read=%0d write=%0d", rd_cyc, wr_cyc,
                     is_hit ? 0 : fill_lat, (is_hit || !dty) ? 0 : wb_lat);
        end
        exp_hits++;
        if (!is_hit) exp_misses++;
        idle_inputs();
        #1;
        tests_run++;
        if (outs() !== default_outs) begin
            tests_failed++;
            $display("FAIL idle_after_txn: got %h required %h", outs(), default_outs);
        end
        @(negedge clk);
    endtask

    task automatic check_counters(input string tag);
`ifdef CACHE_PERF_CTR_EN
        tests_run++;
        if (bus.hit_count !== exp_hits || bus.miss_count !== exp_misses) begin
            tests_failed++;
            $display("FAIL %s: hit_count=%0d miss_count=%0d required %0d %0d",
                     tag, bus.hit_count, bus.miss_count, exp_hits, exp_misses);
        end
`else
        if (tag.len() == 0) $display("[TB] unnamed counter check");
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (outs() !== default_outs) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required %h", outs(), default_outs);
        end
        exp_hits = 0; exp_misses = 0;
        check_counters("reset_counters");
        rst = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (outs() !== default_outs) begin
            tests_failed++;
            $display("FAIL idle_check: got %h required %h", outs(), default_outs);
        end
        @(negedge clk);
    endtask

    task automatic test_read_hit();  do_txn(0, 0, 1, 1, 0, 0, 1, 1); endtask
    task automatic test_write_hit(); do_txn(1, 0, 1, 0, 0, 1, 1, 1); endtask
    task automatic test_both_high(); do_txn(1, 1, 1, 1, 0, 0, 1, 1); endtask
    task automatic test_clean_miss(); do_txn(0, 0, 0, 0, 0, 0, 4, 1); endtask
    task automatic test_dirty_miss(); do_txn(1, 0, 0, 0, 1, 1, 3, 4); endtask

    task automatic test_reset_mid_miss();
        bus.mem_write = 1'b1; bus.dirty = 1'b1; bus.lru_out = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (bus.pmem_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL enter_writeback: pmem_write=%0b required 1", bus.pmem_write);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (outs() !== default_outs) begin
            tests_failed++;
            $display("FAIL reset_mid_wb: got %h required %h", outs(), default_outs);
        end
        exp_hits = 0; exp_misses = 0;
        check_counters("reset_mid_wb_counters");
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        do_txn(0, 0, 1, 0, 0, 0, 1, 1);
    endtask

    task automatic test_perf_counters();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        exp_hits = 0; exp_misses = 0;
        @(negedge clk);
        do_txn(0, 0, 1, 0, 0, 0, 1, 1);
        do_txn(1, 0, 1, 1, 0, 0, 1, 1);
        do_txn(0, 0, 1, 1, 0, 0, 1, 1);
        do_txn(0, 0, 0, 0, 0, 1, 2, 1);
        check_counters("perf_3hit_1miss");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_txn($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(1, 6), $urandom_range(1, 6));
        end
        check_counters("random_counters");
    endtask

    initial begin
        default_outs = {10'b0, write_none, write_none, wdata, data_out_0, memory};
        test_reset();
        test_read_hit();
        test_write_hit();
        test_both_high();
        test_clean_miss();
        test_dirty_miss();
        test_reset_mid_miss();
        test_perf_counters();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
